mul_div_seq_ctrl: RTL and testbench

//  Sequencer for the modular multiply/divide cell array.
//  - Reuses one N-cell array row iteratively and stores the partial result between cycles.
//  - Multiply: shift-add, unsigned N x N -> 2N.
//  - Divide: non-restoring, unsigned N / N -> quotient + remainder.
//  - Sits between the system bus/register stage and the array row. Drives the row's
//    MUL_BAR (1 = subtract/divide), Y_ROW, X_IN, P and carry-in controls.

---
 rtl/mul_div_seq_ctrl_pkg.sv | 12 +
 rtl/mul_div_seq_ctrl_if.sv | 14 +
 rtl/mul_div_seq_ctrl_array_row.sv | 23 ++
 rtl/mul_div_seq_ctrl.sv | 90 +++++++++
 tb/tb_mul_div_seq_ctrl.sv | 121 ++++++++++++
 5 files changed

// File: rtl/mul_div_seq_ctrl_pkg.sv
// mul_div_pkg: shared state encoding, mode constants and width helper
// for the iterative multiply/divide sequencer.
package mul_div_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, FIN = 2'd3} state_t;
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;
    function automatic int clog2(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/mul_div_seq_ctrl_if.sv
// mul_div_seq_ctrl_if: request/result bundle between the bus stage and the sequencer.
interface mul_div_seq_ctrl_if #(parameter int N = 4);
    logic         start;
    logic         mul_bar;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result_hi;
    logic [N-1:0] result_lo;
    logic         div0;
    modport master (output start, mul_bar, a, b, input busy, done, result_hi, result_lo, div0);
    modport slave (input start, mul_bar, a, b, output busy, done, result_hi, result_lo, div0);
endinterface

// File: rtl/mul_div_seq_ctrl_array_row.sv
// array_row: one row of add/subtract cells chained on carry; i_mul_bar=1 subtracts i_x_in.
// o_sign is bit N of the (N+1)-bit result whose top operand bit is i_in_prev.
module array_row #(parameter int N = 4) (
    input  logic [N-1:0] i_y_row,
    input  logic [N-1:0] i_x_in,
    input  logic         i_in_prev,
    input  logic         i_mul_bar,
    output logic [N-1:0] o_out,
    output logic         o_carry,
    output logic         o_sign
);
    logic [N:0]   w_c;
    logic [N-1:0] w_xb;
    assign w_c[0] = i_mul_bar;
    assign w_xb   = i_x_in ^ {N{i_mul_bar}};
    genvar g;
    for (g = 0; g < N; g++) begin : g_cell
        assign o_out[g]   = i_y_row[g] ^ w_xb[g] ^ w_c[g];
        assign w_c[g + 1] = (i_y_row[g] & w_xb[g]) | (w_c[g] & (i_y_row[g] ^ w_xb[g]));
    end
    assign o_carry = w_c[N];
    assign o_sign  = i_in_prev ^ i_mul_bar ^ w_c[N];
endmodule

// File: rtl/mul_div_seq_ctrl.sv
// mul_div_seq_ctrl: iterates one array row N times for shift-add multiply
// or non-restoring divide, holding the partial result between cycles.
module mul_div_seq_ctrl
    import mul_div_pkg::*;
#(parameter int N = 4) (
    input logic clk,
    input logic rst,
    mul_div_seq_ctrl_if.slave io_bus
);
    localparam int CW = clog2(N);
    state_t       r_state;
    logic [CW-1:0] r_cnt;
    logic         r_mode, r_busy, r_done, r_div0;
    logic [N-1:0] r_a, r_b, r_lo, r_res_hi, r_res_lo;
    logic [N:0]   r_hi;
    logic         w_div_calc, w_sub, w_prev, w_carry, w_sign, w_div0;
    logic [N-1:0] w_y, w_x, w_out;
    // r_hi is acc_hi (mul) or the signed N+1-bit remainder (div); r_lo is acc_lo or quotient
    always_comb begin
        w_div_calc = r_state == CALC && r_mode == MODE_DIV;
        w_sub      = w_div_calc && !r_hi[N];
        w_y        = w_div_calc ? {r_hi[N-2:0], r_lo[N-1]} : r_hi[N-1:0];
        w_prev     = w_div_calc ? r_hi[N-1] : r_hi[N];
        w_x        = r_mode == MODE_DIV ? r_b : (r_lo[0] ? r_a : '0);
        w_div0     = r_mode == MODE_DIV && r_b == '0;
    end
    array_row #(.N(N)) u_row (
        .i_y_row   (w_y),
        .i_x_in    (w_x),
        .i_in_prev (w_prev),
        .i_mul_bar (w_sub),
        .o_out     (w_out),
        .o_carry   (w_carry),
        .o_sign    (w_sign)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mode   <= MODE_MUL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (io_bus.start) begin
                    r_a     <= io_bus.a;
                    r_b     <= io_bus.b;
                    r_mode  <= io_bus.mul_bar;
                    r_hi    <= '0;
                    r_lo    <= io_bus.mul_bar == MODE_DIV ? io_bus.a : io_bus.b;
                    r_cnt   <= CW'(N - 1);
                    r_div0  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= (io_bus.mul_bar == MODE_DIV && io_bus.b == '0) ? FIN : CALC;
                end
                CALC: begin
                    r_hi    <= r_mode == MODE_DIV ? {w_sign, w_out} : {1'b0, w_carry, w_out[N-1:1]};
                    r_lo    <= r_mode == MODE_DIV ? {r_lo[N-2:0], ~w_sign} : {w_out[0], r_lo[N-1:1]};
                    r_cnt   <= r_cnt - CW'(1);
                    r_state <= r_cnt != '0 ? CALC : (r_mode == MODE_DIV ? FIX : FIN);
                end
                FIX: begin
                    r_hi    <= r_hi[N] ? {1'b0, w_out} : r_hi;
                    r_state <= FIN;
                end
                FIN: begin
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_res_hi <= w_div0 ? r_a : r_hi[N-1:0];
                    r_res_lo <= w_div0 ? '1 : r_lo;
                    r_div0   <= w_div0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.result_hi = r_res_hi;
    assign io_bus.result_lo = r_res_lo;
    assign io_bus.div0      = r_div0;
endmodule

// File: tb/tb_mul_div_seq_ctrl.sv
// tb_mul_div_seq_ctrl: scoreboard bench; expected results queued at issue, checked on DONE.
module tb_mul_div_seq_ctrl;
    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       div0;
    } res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    res_t exp_q[$];
    res_t mon_e;
    mul_div_seq_ctrl_if #(.N(4)) bus ();
    mul_div_seq_ctrl #(.N(4)) dut (.clk(clk), .rst(rst), .io_bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic res_t model(input logic mb, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'd0, a} * {4'd0, b};
        if (!mb) return '{hi: p[7:4], lo: p[3:0], div0: 1'b0};
        if (b == 4'd0) return '{hi: a, lo: 4'hF, div0: 1'b1};
        return '{hi: a % b, lo: a / b, div0: 1'b0};
    endfunction
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            n_done++;
            chk("q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("result_hi", 32'(bus.result_hi), 32'(mon_e.hi));
                chk("result_lo", 32'(bus.result_lo), 32'(mon_e.lo));
                chk("div0", 32'(bus.div0), 32'(mon_e.div0));
            end
        end
    end
    task automatic run_op(input logic mb, input logic [3:0] a, input logic [3:0] b, input int lat);
        int k;
        @(negedge clk);
        bus.start = 1'b1; bus.mul_bar = mb; bus.a = a; bus.b = b;
        exp_q.push_back(model(mb, a, b));
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        chk("busy_after_accept", 32'(bus.busy), 1);
        chk("div0_clear_on_accept", 32'(bus.div0), 0);
        while (!bus.done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(lat));
        chk("busy_at_done", 32'(bus.busy), 0);
    endtask
    initial begin
        int d0;
        logic [3:0] ra, rb;
        logic rm;
        bus.start = 1'b0; bus.mul_bar = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_hi", 32'(bus.result_hi), 0);
        chk("rst_lo", 32'(bus.result_lo), 0);
        chk("rst_div0", 32'(bus.div0), 0);
        run_op(1'b0, 4'd13, 4'd11, 5);
        run_op(1'b0, 4'd15, 4'd15, 5);
        run_op(1'b0, 4'd0, 4'd9, 5);
        run_op(1'b1, 4'd13, 4'd3, 6);
        run_op(1'b1, 4'd2, 4'd7, 6);
        run_op(1'b1, 4'd7, 4'd0, 1);
        run_op(1'b0, 4'd3, 4'd5, 5);
        // START hammered while busy: only the first request may produce a DONE
        @(negedge clk);
        bus.start = 1'b1; bus.mul_bar = 1'b0; bus.a = 4'd13; bus.b = 4'd11;
        exp_q.push_back(model(1'b0, 4'd13, 4'd11));
        d0 = n_done;
        for (int i = 0; i < 30 && !bus.done; i++) begin
            @(negedge clk);
            bus.start = !bus.done; bus.mul_bar = 1'($urandom); bus.a = 4'($urandom); bus.b = 4'($urandom);
        end
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("single_done", 32'(n_done - d0), 1);
        chk("hold_hi", 32'(bus.result_hi), 32'h8);
        chk("hold_lo", 32'(bus.result_lo), 32'hF);
        // reset during the second CALC cycle aborts the operation
        @(negedge clk);
        bus.start = 1'b1; bus.mul_bar = 1'b0; bus.a = 4'd13; bus.b = 4'd11;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_hi", 32'(bus.result_hi), 0);
        chk("abort_lo", 32'(bus.result_lo), 0);
        chk("abort_div0", 32'(bus.div0), 0);
        d0 = n_done;
        repeat (8) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 0);
        run_op(1'b0, 4'd6, 4'd5, 5);
        for (int i = 0; i < 12; i++) begin
            rm = 1'($urandom); ra = 4'($urandom); rb = (i % 4 == 3) ? 4'd0 : 4'($urandom);
            run_op(rm, ra, rb, !rm ? 5 : (rb == 4'd0 ? 1 : 6));
        end
        repeat (3) @(negedge clk);
        chk("q_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
